// File: rtl/control_signals.sv
// Shared decode definitions: RV32I opcodes, ALU control ops, immediate kinds and decoded payload.
package control_signals;

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned OPC_W    = 7;
   localparam int unsigned ALU_OP_W = 4;
   localparam int unsigned REG_W    = 5;

   localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD      = 4'd0,
      ALU_SUB      = 4'd1,
      ALU_SHIFT_LL = 4'd2,
      ALU_SLT      = 4'd3,
      ALU_SLTU     = 4'd4,
      ALU_XOR      = 4'd5,
      ALU_SHIFT_RL = 4'd6,
      ALU_SHIFT_RA = 4'd7,
      ALU_OR       = 4'd8,
      ALU_AND      = 4'd9,
      ALU_PASS_B   = 4'd10,
      ALU_PC_INC   = 4'd11
   } alu_cntrl_t;

   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_U, IMM_NONE} ImmType;

   typedef struct packed {
      logic [ALU_OP_W-1:0] alu_op;
      logic [DATA_W-1:0]   op_a;
      logic [DATA_W-1:0]   op_b;
      logic [REG_W-1:0]    rd;
      logic                wb_en;
   } dec_t;

   // funct3 plus the alternate bit (instr[30]) to the register/immediate arithmetic op
   function automatic alu_cntrl_t arith_op(input logic [2:0] funct3, input logic alt);
      alu_cntrl_t op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SHIFT_LL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SHIFT_RA : ALU_SHIFT_RL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate builder; all immediates sign-extend from instr[31].
module imm_gen
   import control_signals::*;
(
   input  logic [DATA_W-1:0] instr,
   input  ImmType            imm_type,
   output logic [DATA_W-1:0] imm_c
);

   always_comb begin
      imm_c = '0;
      case (imm_type)
         IMM_I:   imm_c = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_U:   imm_c = {instr[31:12], 12'b0};
         default: imm_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage producing alu_op and both ALU operands behind a valid/ready register.
// Optional ALU_DECODE_ILLEGAL_EN adds the illegal flag and a saturating illegal-instruction counter.
module alu_decode_stage
   import control_signals::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter alu_cntrl_t  RST_OP = ALU_ADD
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     instr,
   input  logic [XLEN-1:0]     pc,
   input  logic [XLEN-1:0]     rs1_data,
   input  logic [XLEN-1:0]     rs2_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [XLEN-1:0]     op_a,
   output logic [XLEN-1:0]     op_b,
   output logic [REG_W-1:0]    rd,
   output logic                wb_en
`ifdef ALU_DECODE_ILLEGAL_EN
   ,
   output logic                illegal,
   output logic [15:0]         illegal_cnt
`endif
);

   localparam int unsigned CNT_W = 16;

   logic [OPC_W-1:0] opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic [REG_W-1:0] rd_f;
   logic             is_shift;
   ImmType           imm_type;
   logic [XLEN-1:0]  imm;
   dec_t             dec;
   logic             bad;
   logic             in_fire;
   logic             out_fire;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign rd_f     = instr[11:7];
   assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

   assign in_ready = !out_valid || out_ready;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // Immediate kind depends on opcode only
   always_comb begin
      imm_type = IMM_NONE;
      case (opcode)
         OPC_OP_IMM, OPC_LOAD: imm_type = IMM_I;
         OPC_STORE:            imm_type = IMM_S;
         OPC_LUI, OPC_AUIPC:   imm_type = IMM_U;
         default:              imm_type = IMM_NONE;
      endcase
   end

   imm_gen u_imm_gen (
      .instr    (instr),
      .imm_type (imm_type),
      .imm_c    (imm)
   );

   always_comb begin
      dec        = '0;
      dec.alu_op = RST_OP;
      bad        = 1'b0;
      case (opcode)
         OPC_OP: begin
            bad = !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            dec.alu_op = arith_op(funct3, funct7[5]);
            dec.op_a   = rs1_data;
            dec.op_b   = rs2_data;
            dec.rd     = rd_f;
            dec.wb_en  = 1'b1;
         end
         OPC_OP_IMM: begin
            // SUB has no immediate form; instr[30] only matters for the right shift
            bad = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
            dec.alu_op = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
            dec.op_a   = rs1_data;
            dec.op_b   = is_shift ? XLEN'(imm[4:0]) : imm;
            dec.rd     = rd_f;
            dec.wb_en  = 1'b1;
         end
         OPC_LUI: begin
            dec.alu_op = ALU_PASS_B;
            dec.op_b   = imm;
            dec.rd     = rd_f;
            dec.wb_en  = 1'b1;
         end
         OPC_AUIPC: begin
            dec.alu_op = ALU_ADD;
            dec.op_a   = pc;
            dec.op_b   = imm;
            dec.rd     = rd_f;
            dec.wb_en  = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            dec.alu_op = ALU_PC_INC;
            dec.op_a   = pc;
            dec.rd     = rd_f;
            dec.wb_en  = 1'b1;
         end
         OPC_LOAD: begin
            dec.alu_op = ALU_ADD;
            dec.op_a   = rs1_data;
            dec.op_b   = imm;
            dec.rd     = rd_f;
            dec.wb_en  = 1'b1;
         end
         OPC_STORE: begin
            dec.alu_op = ALU_ADD;
            dec.op_a   = rs1_data;
            dec.op_b   = imm;
         end
         OPC_BRANCH: begin
            dec.alu_op = ALU_SUB;
            dec.op_a   = rs1_data;
            dec.op_b   = rs2_data;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         dec        = '0;
         dec.alu_op = RST_OP;
      end
      if (dec.rd == '0) dec.wb_en = 1'b0;
   end

   // Output register: a new entry replaces the old one when both transfers coincide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_op    <= RST_OP;
         op_a      <= '0;
         op_b      <= '0;
         rd        <= '0;
         wb_en     <= 1'b0;
      end else if (in_fire) begin
         out_valid <= 1'b1;
         alu_op    <= dec.alu_op;
         op_a      <= dec.op_a;
         op_b      <= dec.op_b;
         rd        <= dec.rd;
         wb_en     <= dec.wb_en;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ALU_DECODE_ILLEGAL_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal     <= 1'b0;
         illegal_cnt <= '0;
      end else if (in_fire) begin
         illegal <= bad;
         if (bad && (illegal_cnt != {CNT_W{1'b1}})) illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Table-driven scoreboard bench for alu_decode_stage; define ALU_DECODE_ILLEGAL_EN to also check illegal/illegal_cnt.
module tb_alu_decode_stage;
   import control_signals::*;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        wb;
      logic        ill;
   } vec_t;

   typedef struct {
      int          idx;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        wb;
      logic        ill;
      logic [15:0] cnt;
   } exp_t;

   localparam int NVEC = 19;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_op;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  rd;
   logic        wb_en;
`ifdef ALU_DECODE_ILLEGAL_EN
   logic        illegal;
   logic [15:0] illegal_cnt;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   vec_t        vecs[NVEC];
   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] cnt_model = '0;
   int          waits;

   always #5 clk = ~clk;

   alu_decode_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_op    (alu_op),
      .op_a      (op_a),
      .op_b      (op_b),
      .rd        (rd),
      .wb_en     (wb_en)
`ifdef ALU_DECODE_ILLEGAL_EN
      ,
      .illegal     (illegal),
      .illegal_cnt (illegal_cnt)
`endif
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                               input logic [31:0] r2, input alu_cntrl_t op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] d, input logic w, input logic il);
      vec_t v;
      v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
      v.op = op; v.a = a; v.b = b; v.rd = d; v.wb = w; v.ill = il;
      return v;
   endfunction

   task automatic push(input vec_t v, input int idx);
      exp_t e;
      if (v.ill && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
      e.idx = idx; e.op = v.op; e.a = v.a; e.b = v.b; e.rd = v.rd;
      e.wb = v.wb; e.ill = v.ill; e.cnt = cnt_model;
      sb.push_back(e);
   endtask

   // Drive one transaction and record its expectation once it is accepted
   task automatic send(input vec_t v, input int idx, output int w);
      @(posedge clk); #1;
      instr = v.instr; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2; in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout[%0d]: in_ready stuck at 0, required 1", idx);
      end else begin
         push(v, idx);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 0, 32'(sb.size()), 32'd0);
   endtask

   // Scoreboard monitor: compare on every output transfer
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 0, 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("alu_op", mon_e.idx, 32'(alu_op), 32'(mon_e.op));
            chk("op_a",   mon_e.idx, op_a, mon_e.a);
            chk("op_b",   mon_e.idx, op_b, mon_e.b);
            chk("rd",     mon_e.idx, 32'(rd), 32'(mon_e.rd));
            chk("wb_en",  mon_e.idx, 32'(wb_en), 32'(mon_e.wb));
`ifdef ALU_DECODE_ILLEGAL_EN
            chk("illegal",     mon_e.idx, 32'(illegal), 32'(mon_e.ill));
            chk("illegal_cnt", mon_e.idx, 32'(illegal_cnt), 32'(mon_e.cnt));
`endif
         end
      end
   end

   task automatic chk_reset_vals(input int idx);
      chk("rst_out_valid", idx, 32'(out_valid), 32'd0);
      chk("rst_alu_op",    idx, 32'(alu_op), 32'(ALU_ADD));
      chk("rst_op_a",      idx, op_a, 32'd0);
      chk("rst_op_b",      idx, op_b, 32'd0);
      chk("rst_rd",        idx, 32'(rd), 32'd0);
      chk("rst_wb_en",     idx, 32'(wb_en), 32'd0);
      chk("rst_in_ready",  idx, 32'(in_ready), 32'd1);
`ifdef ALU_DECODE_ILLEGAL_EN
      chk("rst_illegal_cnt", idx, 32'(illegal_cnt), 32'd0);
`endif
   endtask

   initial begin
      vecs[0]  = mk(32'h00B50533, 32'h0,    32'd5,        32'd7,        ALU_ADD,      32'd5,        32'd7,        5'd10, 1'b1, 1'b0);
      vecs[1]  = mk(32'h40B50533, 32'h0,    32'd9,        32'd4,        ALU_SUB,      32'd9,        32'd4,        5'd10, 1'b1, 1'b0);
      vecs[2]  = mk(32'h40355513, 32'h0,    32'h80000000, 32'h0,        ALU_SHIFT_RA, 32'h80000000, 32'd3,        5'd10, 1'b1, 1'b0);
      vecs[3]  = mk(32'h123452B7, 32'h0,    32'h0,        32'h0,        ALU_PASS_B,   32'h0,        32'h12345000, 5'd5,  1'b1, 1'b0);
      vecs[4]  = mk(32'h000000EF, 32'h100,  32'h0,        32'h0,        ALU_PC_INC,   32'h100,      32'h0,        5'd1,  1'b1, 1'b0);
      vecs[5]  = mk(32'hFFFFFFFF, 32'h44,   32'h55,       32'h66,       ALU_ADD,      32'h0,        32'h0,        5'd0,  1'b0, 1'b1);
      vecs[6]  = mk(32'hFFC12303, 32'h0,    32'h1000,     32'h0,        ALU_ADD,      32'h1000,     32'hFFFFFFFC, 5'd6,  1'b1, 1'b0);
      vecs[7]  = mk(32'hFE50AC23, 32'h0,    32'h200,      32'hAB,       ALU_ADD,      32'h200,      32'hFFFFFFF8, 5'd0,  1'b0, 1'b0);
      vecs[8]  = mk(32'h00208063, 32'h0,    32'h11,       32'h3,        ALU_SUB,      32'h11,       32'h3,        5'd0,  1'b0, 1'b0);
      vecs[9]  = mk(32'hFFFFF197, 32'h2000, 32'h0,        32'h0,        ALU_ADD,      32'h2000,     32'hFFFFF000, 5'd3,  1'b1, 1'b0);
      vecs[10] = mk(32'h00208033, 32'h0,    32'h4,        32'h5,        ALU_ADD,      32'h4,        32'h5,        5'd0,  1'b0, 1'b0);
      vecs[11] = mk(32'hFFF38393, 32'h0,    32'h7,        32'h0,        ALU_ADD,      32'h7,        32'hFFFFFFFF, 5'd7,  1'b1, 1'b0);
      vecs[12] = mk(32'h02B50533, 32'h0,    32'h1,        32'h2,        ALU_ADD,      32'h0,        32'h0,        5'd0,  1'b0, 1'b1);
      vecs[13] = mk(32'h003130B3, 32'h0,    32'h1,        32'hFFFFFFFF, ALU_SLTU,     32'h1,        32'hFFFFFFFF, 5'd1,  1'b1, 1'b0);
      vecs[14] = mk(32'h41F09093, 32'h0,    32'h1,        32'h0,        ALU_ADD,      32'h0,        32'h0,        5'd0,  1'b0, 1'b1);
      vecs[15] = mk(32'h000280E7, 32'h40,   32'h9,        32'h0,        ALU_PC_INC,   32'h40,       32'h0,        5'd1,  1'b1, 1'b0);
      vecs[16] = mk(32'h40000093, 32'h0,    32'h0,        32'h0,        ALU_ADD,      32'h0,        32'h400,      5'd1,  1'b1, 1'b0);
      vecs[17] = mk(32'h0040D093, 32'h0,    32'hF0,       32'h0,        ALU_SHIFT_RL, 32'hF0,       32'h4,        5'd1,  1'b1, 1'b0);
      vecs[18] = mk(32'h0000000F, 32'h0,    32'h3,        32'h3,        ALU_ADD,      32'h0,        32'h0,        5'd0,  1'b0, 1'b1);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
      #3;
      chk_reset_vals(0);
      @(negedge clk);
      rst_n = 1'b1;

      // Full table back-to-back with the sink always ready
      for (int i = 0; i < NVEC; i++) begin
         send(vecs[i], i, waits);
         chk("stream_wait", i, 32'(waits), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Backpressure: held entry frozen, nothing consumed for three cycles
      out_ready = 1'b0;
      send(vecs[0], 100, waits);
      @(posedge clk); #1;
      instr = vecs[3].instr; pc = vecs[3].pc; rs1_data = vecs[3].rs1; rs2_data = vecs[3].rs2;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_in_ready",  k, 32'(in_ready), 32'd0);
         chk("bp_out_valid", k, 32'(out_valid), 32'd1);
         chk("bp_alu_op",    k, 32'(alu_op), 32'(ALU_ADD));
         chk("bp_op_a",      k, op_a, 32'd5);
         chk("bp_op_b",      k, op_b, 32'd7);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 0, 32'(in_ready), 32'd1);
      push(vecs[3], 103);
      send(vecs[4], 104, waits);
      chk("b2b_wait", 104, 32'(waits), 32'd0);
      send(vecs[6], 106, waits);
      chk("b2b_wait", 106, 32'(waits), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Asynchronous reset while an entry is held
      out_ready = 1'b0;
      send(vecs[5], 200, waits);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", 200, 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals(200);
      sb.delete();
      cnt_model = '0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Stage still works after reset, counter restarts from zero
      send(vecs[12], 300, waits);
      send(vecs[1], 301, waits);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

endmodule
